// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues single outstanding imem requests,
// buffers one instruction for decode. Optional FETCH_ALIGN_CHECK_EN adds misaligned-redirect halt.

module pc_adder #(
  parameter int N   = 32,
  parameter int INC = 4
) (
  input  logic [N-1:0] pc_i,
  output logic [N-1:0] pc_seq_o
);
  localparam logic [N-1:0] INC_N = N'(INC);
  // Wraps modulo 2^N; carry out intentionally dropped.
  assign pc_seq_o = pc_i + INC_N;
endmodule

module fetch_sequencer #(
  parameter int          N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = '0,
  parameter int          INC          = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic         misalign_err
`endif
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
`endif

  state_t       state_q;
  logic [N-1:0] pc_q, pc_pending_q, pc_seq;
  logic         squash_q;
  logic         out_valid_q;
  logic [N-1:0] instr_q, instr_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         misalign_q;
  logic         redir_bad;
  assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00) && (state_q != HALT);
`endif

  pc_adder #(.N(N), .INC(INC)) u_pc_adder (
    .pc_i     (pc_q),
    .pc_seq_o (pc_seq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VECTOR;
      pc_pending_q <= '0;
      squash_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      // Consume/flush first; a reload below takes precedence.
      if (out_valid_q && instr_ready) out_valid_q <= 1'b0;
      if (redirect_valid)             out_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (redirect_valid) begin
            pc_q    <= redirect_target;
            state_q <= REQ;
          end else if (!out_valid_q || instr_ready) begin
            state_q <= REQ;
          end
        end
        REQ: begin
          // Address stays on the bus until granted; the redirect is deferred.
          if (redirect_valid) begin
            pc_pending_q <= redirect_target;
            squash_q     <= 1'b1;
          end
          if (imem_gnt) state_q <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (squash_q || redirect_valid) begin
              pc_q     <= redirect_valid ? redirect_target : pc_pending_q;
              squash_q <= 1'b0;
              state_q  <= REQ;
            end else begin
              out_valid_q <= 1'b1;
              instr_q     <= imem_rdata;
              instr_pc_q  <= pc_q;
              pc_q        <= pc_seq;
              state_q     <= IDLE;
            end
          end else if (redirect_valid) begin
            pc_pending_q <= redirect_target;
            squash_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
`ifdef FETCH_ALIGN_CHECK_EN
        HALT: state_q <= HALT;
`endif
      endcase

`ifdef FETCH_ALIGN_CHECK_EN
      if (redir_bad) begin
        state_q     <= HALT;
        squash_q    <= 1'b0;
        out_valid_q <= 1'b0;
        misalign_q  <= 1'b1;
      end
`endif
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = out_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a memory responder with tunable latency,
// expected (pc, instr) pairs queued per scenario and popped as decode consumes them.

module tb_fetch_sequencer;
  localparam int N = 32;

  logic         clk = 1'b0, rst = 1'b1;
  logic         redirect_valid = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, instr_ready = 1'b0;
  logic [N-1:0] redirect_target = '0, imem_rdata = '0;
  logic         imem_req, instr_valid;
  logic [N-1:0] imem_addr, instr, instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         misalign_err;
`endif

  int checks = 0, errors = 0;
  int gnt_wait = 0, rv_wait = 0;
  bit fixed_data = 1'b0;
  int g_cnt = 0, rv_cnt = 0;
  bit busy = 1'b0;
  logic [N-1:0] pend_addr = '0;

  typedef struct packed {logic [N-1:0] pc; logic [N-1:0] data;} exp_t;
  exp_t         exp_q[$];
  logic [N-1:0] grant_q[$];

  always #5 clk = ~clk;

  fetch_sequencer #(.N(N), .RESET_VECTOR(32'h0), .INC(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  function automatic logic [N-1:0] word_at(input logic [N-1:0] a);
    if (fixed_data) return 32'h0000_0013;
    return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  function automatic exp_t mk(input logic [N-1:0] pc, input logic [N-1:0] data);
    exp_t e;
    e.pc = pc;
    e.data = data;
    return e;
  endfunction

  // Memory: grants after gnt_wait cycles of held request, answers rv_wait cycles later.
  // A response already in flight is still delivered across a reset.
  always @(negedge clk) begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (busy) begin
      if (rv_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(pend_addr);
        busy        = 1'b0;
      end else rv_cnt--;
    end else if (imem_req === 1'b1 && !rst) begin
      if (g_cnt >= gnt_wait) begin
        imem_gnt  = 1'b1;
        busy      = 1'b1;
        rv_cnt    = rv_wait;
        pend_addr = imem_addr;
        g_cnt     = 0;
        grant_q.push_back(imem_addr);
      end else g_cnt++;
    end else g_cnt = 0;
  end

  // Decode side: every consumed instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr got pc=%h instr=%h, expected none", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if (instr_pc !== e.pc || instr !== e.data) begin
          errors++;
          $display("FAIL deliver got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, e.pc, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
    gnt_wait = 0; rv_wait = 0;
    repeat (5) tick();
    exp_q.delete();
    grant_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
    repeat (5) tick();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== '0 || instr_pc !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b vld=%b instr=%h pc=%h expected all zero", imem_req, instr_valid, instr, instr_pc);
    end
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b expected 0", misalign_err); end
`endif
    exp_q.delete(); grant_q.delete();
    rst = 1'b0;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_after_reset got req=%b expected 0", imem_req); end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    int cyc;
    fixed_data = 1'b1;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(N'(4 * k), 32'h0000_0013));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin tick(); cyc++; end
    instr_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL seq_drain got %0d left expected 0", exp_q.size()); end
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL seq_throughput got %0d cycles expected 10", cyc); end
    checks++;
    if (grant_q.size() < 3 || grant_q[0] !== 32'h0 || grant_q[1] !== 32'h4 || grant_q[2] !== 32'h8) begin
      errors++;
      $display("FAIL seq_addrs got %0d grants expected 0,4,8", grant_q.size());
    end
    fixed_data = 1'b0;
  endtask

  task automatic test_stall();
    int cyc;
    do_reset();
    exp_q.push_back(mk(32'h0, word_at(32'h0)));
    exp_q.push_back(mk(32'h4, word_at(32'h4)));
    cyc = 0;
    while (instr_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_fill got vld=%b expected 1", instr_valid); end
    repeat (5) begin
      tick();
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== word_at(32'h0) || instr_pc !== 32'h0) begin
        errors++;
        $display("FAIL stall_hold got req=%b vld=%b instr=%h pc=%h expected 0 1 %h 0", imem_req, instr_valid, instr, instr_pc, word_at(32'h0));
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL stall_resume got req=%b addr=%h expected 1 00000004", imem_req, imem_addr);
    end
    wait_drain(30);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_wait();
    int cyc;
    do_reset();
    rv_wait = 3;
    instr_ready = 1'b1;
    exp_q.push_back(mk(32'h100, word_at(32'h100)));
    cyc = 0;
    while (grant_q.size() == 0 && cyc < 20) begin tick(); cyc++; end
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    wait_drain(40);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL redir_wait_drain got %0d left expected 0", exp_q.size()); end
    checks++;
    if (grant_q.size() < 2 || grant_q[1] !== 32'h100) begin
      errors++;
      $display("FAIL redir_wait_addr got %0d grants expected second at 00000100", grant_q.size());
    end
    rv_wait = 0;
  endtask

  task automatic test_redirect_req();
    do_reset();
    gnt_wait = 3;
    instr_ready = 1'b1;
    exp_q.push_back(mk(32'h200, word_at(32'h200)));
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    repeat (2) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
        errors++;
        $display("FAIL redir_req_hold got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
      end
      tick();
    end
    wait_drain(60);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL redir_req_drain got %0d left expected 0", exp_q.size()); end
    checks++;
    if (grant_q.size() < 2 || grant_q[0] !== 32'h0 || grant_q[1] !== 32'h200) begin
      errors++;
      $display("FAIL redir_req_addrs got %0d grants expected 0 then 00000200", grant_q.size());
    end
    gnt_wait = 0;
  endtask

  task automatic test_redirect_rvalid();
    int cyc;
    do_reset();
    rv_wait = 2;
    instr_ready = 1'b1;
    exp_q.push_back(mk(32'h300, word_at(32'h300)));
    cyc = 0;
    while (grant_q.size() == 0 && cyc < 20) begin tick(); cyc++; end
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++;
      $display("FAIL redir_rvalid got req=%b addr=%h expected 1 00000300", imem_req, imem_addr);
    end
    wait_drain(30);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL redir_rvalid_drain got %0d left expected 0", exp_q.size()); end
    rv_wait = 0;
  endtask

  task automatic test_redirect_idle();
    int cyc;
    do_reset();
    cyc = 0;
    while (instr_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    redirect_valid = 1'b1; redirect_target = 32'h80;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      errors++;
      $display("FAIL redir_idle got vld=%b req=%b addr=%h expected 0 1 00000080", instr_valid, imem_req, imem_addr);
    end
    exp_q.push_back(mk(32'h80, word_at(32'h80)));
    instr_ready = 1'b1;
    wait_drain(30);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL redir_idle_drain got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first got req=%b addr=%h expected 1 fffffffc", imem_req, imem_addr);
    end
    exp_q.push_back(mk(32'hFFFF_FFFC, word_at(32'hFFFF_FFFC)));
    exp_q.push_back(mk(32'h0, word_at(32'h0)));
    instr_ready = 1'b1;
    wait_drain(30);
    checks++;
    if (exp_q.size() != 0 || grant_q.size() < 2 || grant_q[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next got %0d left %0d grants expected 0 left, second grant 00000000", exp_q.size(), grant_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    rv_wait = 1;
    instr_ready = 1'b1;
    cyc = 0;
    while (grant_q.size() == 0 && cyc < 20) begin tick(); cyc++; end
    rst = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got req=%b vld=%b expected 0 0", imem_req, instr_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL stale_rvalid got vld=%b req=%b addr=%h expected 0 1 00000000", instr_valid, imem_req, imem_addr);
    end
    rv_wait = 0;
    exp_q.push_back(mk(32'h0, word_at(32'h0)));
    wait_drain(30);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_reset_drain got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int  cyc;
    bit  ok;
    do_reset();
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(N'(4 * k), word_at(N'(4 * k))));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      gnt_wait    = $urandom_range(0, 2);
      rv_wait     = $urandom_range(0, 2);
      instr_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    instr_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d left expected 0", exp_q.size()); end
    ok = (grant_q.size() >= 8);
    for (int k = 0; k < 8 && ok; k++) if (grant_q[k] !== N'(4 * k)) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_addrs got %0d grants expected 0..1c in order", grant_q.size()); end
    gnt_wait = 0; rv_wait = 0;
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset();
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h102;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (misalign_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_halt got err=%b req=%b vld=%b expected 1 0 0", misalign_err, imem_req, instr_valid);
    end
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    repeat (4) begin
      tick();
      checks++;
      if (misalign_err !== 1'b1 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL misalign_sticky got err=%b req=%b expected 1 0", misalign_err, imem_req);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b expected 0", misalign_err); end
    rst = 1'b0;
    exp_q.delete(); grant_q.delete();
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL misalign_restart got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
    exp_q.push_back(mk(32'h0, word_at(32'h0)));
    wait_drain(30);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL misalign_drain got %0d left expected 0", exp_q.size()); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_rvalid();
    test_redirect_idle();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
`ifdef FETCH_ALIGN_CHECK_EN
    test_misalign();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the RISC-V core. It owns the program counter register and advances it by a fixed increment through an instantiated pc_adder. It issues one-at-a-time requests to instruction memory over a req/gnt + rvalid handshake. Fetched instructions go to decode through a one-entry valid/ready output buffer, and branch/jump redirects squash any in-flight fetch.

## Interface
Parameters:
- N, 32, address/data width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- INC, 4, sequential PC increment

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  branch/jump/trap redirect this cycle
- redirect_target  in  N  new fetch address
- imem_req  out  1  fetch request
- imem_addr  out  N  fetch address, valid while imem_req=1
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  N  instruction word
- instr_valid  out  1  output buffer holds an instruction
- instr_ready  in  1  decode accepts this cycle
- instr  out  N  buffered instruction
- instr_pc  out  N  address of buffered instruction
- misalign_err  out  1  present only with FETCH_ALIGN_CHECK_EN

## Operation
- Registers:
  - pc: next fetch address.
  - state ∈ {IDLE, REQ, WAIT, HALT}.
  - squash flag.
  - Output buffer (out_valid, instr, instr_pc).
- pc_adder instance computes pc_seq = pc + INC. The sum wraps modulo 2^N with no carry out.
- imem_req = (state==REQ). imem_addr = pc. Once raised, the request and address are held stable until imem_gnt=1.
- IDLE → REQ when out_valid=0, or when out_valid=1 and instr_ready=1.
- REQ → WAIT on imem_gnt=1.
- WAIT, imem_rvalid=1, no squash and no redirect:
  - Load buffer with imem_rdata, set instr_pc to pc.
  - pc ← pc_seq.
  - → IDLE.
- WAIT, imem_rvalid=1, with squash or redirect:
  - Discard data and clear squash.
  - pc ← latest target.
  - → REQ.
- imem_rvalid is ignored outside WAIT, including responses that arrive after a reset.
- Redirect priority: above everything except rst.
  - Always clears out_valid in the same cycle, overriding instr_ready.
  - IDLE: pc ← target, → REQ.
  - REQ, no gnt: address is held, target is stored in pc_pending, squash ← 1.
  - REQ with gnt, or WAIT without rvalid: pc_pending ← target, squash ← 1.
  - Repeated redirects: the last one wins.
- Buffer: cleared when instr_valid & instr_ready, unless it is reloaded in the same cycle.
- At most one request is outstanding.

## Timing
- Reset values:
  - state = IDLE, pc = RESET_VECTOR, squash = 0.
  - imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0, misalign_err = 0.
- First cycle after rst falls: IDLE. Second cycle: imem_req = 1, imem_addr = RESET_VECTOR.
- Zero-wait memory (gnt in REQ cycle, rvalid next cycle): instr_valid rises 1 cycle after rvalid. Sustained throughput is one instruction per 3 cycles with instr_ready held high.
- Redirect in IDLE, or coincident with rvalid: imem_req with the target appears the next cycle.
- rst asserted mid-transaction: all state returns to reset values next edge. Pending gnt and rvalid are dropped.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with target[1:0] != 2'b00 flushes the buffer and enters HALT.
  - In HALT: imem_req = 0, misalign_err = 1 (sticky), further redirects ignored, exit only via rst.
  - Sequential fetches are never checked.
- Undefined: misalign_err port and HALT state are absent. Targets are used unmodified.

## Test plan
- Reset release, memory grants immediately, rdata=0x00000013, instr_ready=1 → imem_addr 0x0, then 0x4, then 0x8. instr_pc tracks 0x0/0x4/0x8 and instr=0x00000013 each time.
- instr_ready=0 for 5 cycles with buffer full → imem_req stays 0 and instr/instr_pc remain stable. The request to the next address issues the cycle instr_ready returns 1.
- Redirect to 0x100 in WAIT two cycles before rvalid → returned word discarded, instr_valid stays 0, next imem_addr = 0x100.
- Redirect to 0x200 in REQ while gnt=0 → imem_addr stays at the old value until gnt. That response is discarded, then fetch from 0x200.
- pc = 0xFFFFFFFC, sequential fetch → next imem_addr = 0x00000000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 → misalign_err=1, imem_req=0 thereafter. rst clears both and fetch restarts at RESET_VECTOR.
